pipe_if_stage: RTL and testbench
================================

# pipe_if_stage

Instruction-fetch stage and IF/ID pipeline register of the dynamic pipeline CPU. Holds the PC and drives the instruction-memory address. Selects the next PC from the ID-stage control unit's 3-bit `pc_select` and the ID-computed targets. Applies hazard stalls using a small stall counter, and squashes the wrong-path fetch on a taken redirect so that ID only ever decodes valid instructions or NOPs.

## Interface
- `RESET_PC`, 32'h0040_0000, PC loaded on reset
- `EXC_VECTOR`, 32'h0000_0004, handler address used for `pc_select` = 101
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `pc_select`  in  3  from CU: 000 seq, 001 branch, 010 jump, 011 jr/jalr, 100 eret, 101 exception; 110/111 treated as 000
- `branch_target`  in  32  ID: npc + (sext(imm) << 2)
- `jump_target`  in  32  ID: {npc[31:28], index, 2'b00}
- `jr_target`  in  32  rs value from ID forwarding
- `epc`  in  32  CP0 EPC
- `stall_req`  in  1  hazard unit stall request, single-cycle pulse
- `stall_len`  in  2  total stall cycles, 1..3; 0 treated as 1
- `imem_addr`  out  32  byte address, equal to `pc`, asynchronous-read IMEM
- `imem_rdata`  in  32  instruction at `imem_addr`, same cycle
- `if_id_pc`  out  32  PC of instruction in ID
- `if_id_npc`  out  32  `if_id_pc` + 4, used as link value and branch base
- `if_id_instr`  out  32  instruction to CU; 32'h0 (NOP) when invalid
- `if_id_valid`  out  1  ID holds a real instruction
- `stalled`  out  1  high in every stall cycle, including the `stall_req` cycle

## Operation
- Two-state FSM: RUN and STALL. Counter `cnt[1:0]`.
- RUN, `stall_req`=0:
  - `pc` <= next_pc.
  - IF/ID <= {pc, pc+4, imem_rdata, 1}.
  - If the redirect is taken (`pc_select` != 000), IF/ID instead loads {0, 0, 32'h0, 0}. This is the squash.
- RUN, `stall_req`=1:
  - `pc` and IF/ID hold. `pc_select` is ignored, because the operands may be stale.
  - If eff_len > 1, go to STALL with `cnt` = eff_len−2; otherwise stay in RUN.
- STALL:
  - `pc` and IF/ID hold; `pc_select` and `stall_req` are ignored.
  - When `cnt`=0, go to RUN; otherwise `cnt`−1.
- On exit to RUN, ID re-presents the held instruction. Its `pc_select` is evaluated in that cycle.
- next_pc by `pc_select`:
  - 000 → pc+4
  - 001 → `branch_target`
  - 010 → `jump_target`
  - 011 → `jr_target`
  - 100 → `epc`
  - 101 → `EXC_VECTOR`
- All targets have bits [1:0] forced to 00.
- `pc`+4 wraps modulo 2^32 (FFFF_FFFC → 0000_0000).
- `stalled` = `stall_req` | (state==STALL), combinational.

## Timing
- Reset values:
  - `pc`/`imem_addr` = `RESET_PC`; state RUN; `cnt`=0.
  - `if_id_pc`=0, `if_id_npc`=0, `if_id_instr`=0, `if_id_valid`=0; `stalled` follows `stall_req`.
- `rst` overrides everything, including a stall in progress.
- Fetch latency: 1 cycle from PC to ID.
- Taken-redirect penalty: 1 bubble. The target is fetched in the cycle after the redirect.
- A stall of length N freezes `pc` for exactly N cycles.

## Configuration
- `IF_DELAY_SLOT_EN`
  - Defined: MIPS branch delay slot. A taken redirect does not squash; the instruction fetched in the redirect cycle enters ID with valid=1.
  - Undefined: squash as described above.

## Structure
- Shared package/header holds:
  - `pc_select` encodings PCS_SEQ…PCS_EXC
  - NOP = 32'h0
  - default `RESET_PC`/`EXC_VECTOR`
- One sub-module, `npc_mux`: combinational next-PC select plus alignment.
- PC register, IF/ID register and stall FSM live in the top.

## Test plan
- Reset, then 4 sequential cycles → `imem_addr` 0040_0000, …04, …08, …0C; `if_id_valid` first high one cycle after reset release.
- `pc_select`=001 with `branch_target`=0040_0100 while ID holds the instruction at 0040_0004 → next `imem_addr`=0040_0100; ID gets NOP/valid=0, then the instruction at 0040_0100. With `IF_DELAY_SLOT_EN`, ID gets the instruction at 0040_0008 valid.
- `stall_req`=1, `stall_len`=3 at `pc`=0040_0010 → `pc` held for 3 cycles, `stalled`=1 for 3 cycles, IF/ID unchanged; fetch of 0040_0014 in cycle 4.
- `stall_req` together with `pc_select`=011 → redirect ignored; after a 1-cycle stall, `jr_target`=0040_0203 is taken as 0040_0200.
- `pc_select`=101, then later 100 with `epc`=0040_0030 → fetch 0000_0004, then 0040_0030. Separately, `pc_select`=110 → sequential.
- `rst` asserted mid-stall (`cnt`=1) → next cycle `pc`=`RESET_PC`, state RUN, `if_id_valid`=0.

Source files
------------

// File: rtl/pipe_if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select codes,
// FSM states, NOP encoding and default reset/exception addresses.
package pipe_if_stage_pkg;

    typedef enum logic [2:0] {
        PCS_SEQ  = 3'b000,
        PCS_BR   = 3'b001,
        PCS_JMP  = 3'b010,
        PCS_JR   = 3'b011,
        PCS_ERET = 3'b100,
        PCS_EXC  = 3'b101
    } pc_sel_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } if_state_e;

    localparam logic [31:0] NOP                = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0004;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pipe_if_stage_npc_mux.sv
// Combinational next-PC selection with word alignment; also flags whether the
// selection is a taken redirect (anything other than sequential).
module npc_mux
    import pipe_if_stage_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic [2:0]  pc_select,
    input  logic [31:0] pc,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    input  logic [31:0] epc,
    output logic [31:0] next_pc,
    output logic        redirect
);

    logic [31:0] raw_pc;

    always_comb begin
        raw_pc   = pc + 32'd4;
        redirect = 1'b1;
        case (pc_select)
            PCS_BR:   raw_pc = branch_target;
            PCS_JMP:  raw_pc = jump_target;
            PCS_JR:   raw_pc = jr_target;
            PCS_ERET: raw_pc = epc;
            PCS_EXC:  raw_pc = EXC_VECTOR;
            // Sequential and the unused codes 110/111 all fall through to pc+4.
            default:  redirect = 1'b0;
        endcase
        next_pc = word_align(raw_pc);
    end

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage with IF/ID register and hazard-stall FSM.
// Optional macro IF_DELAY_SLOT_EN: keep the redirect-cycle fetch (branch delay slot).
module pipe_if_stage
    import pipe_if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  pc_select,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    input  logic [31:0] epc,
    input  logic        stall_req,
    input  logic [1:0]  stall_len,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_npc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        stalled
);

    if_state_e   state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_npc_q, if_id_npc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;

    logic [31:0] next_pc;
    logic        redirect;
    logic        squash;
    logic [1:0]  eff_len;

    npc_mux #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_npc_mux (
        .pc_select     (pc_select),
        .pc            (pc_q),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .jr_target     (jr_target),
        .epc           (epc),
        .next_pc       (next_pc),
        .redirect      (redirect)
    );

`ifdef IF_DELAY_SLOT_EN
    assign squash = 1'b0;
`else
    assign squash = redirect;
`endif

    assign eff_len = (stall_len == 2'd0) ? 2'd1 : stall_len;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_npc_d   = if_id_npc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;

        case (state_q)
            ST_RUN: begin
                if (stall_req) begin
                    // Redirect operands may be stale during a hazard, so pc_select is ignored.
                    if (eff_len > 2'd1) begin
                        state_d = ST_STALL;
                        cnt_d   = eff_len - 2'd2;
                    end
                end else begin
                    pc_d = next_pc;
                    if (squash) begin
                        if_id_pc_d    = 32'h0;
                        if_id_npc_d   = 32'h0;
                        if_id_instr_d = NOP;
                        if_id_valid_d = 1'b0;
                    end else begin
                        if_id_pc_d    = pc_q;
                        if_id_npc_d   = pc_q + 32'd4;
                        if_id_instr_d = imem_rdata;
                        if_id_valid_d = 1'b1;
                    end
                end
            end
            ST_STALL: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            cnt_q         <= 2'd0;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 32'h0;
            if_id_npc_q   <= 32'h0;
            if_id_instr_q <= NOP;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_npc_q   <= if_id_npc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_npc   = if_id_npc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;
    assign stalled     = stall_req | (state_q == ST_STALL);

endmodule

// File: tb/tb_pipe_if_stage.sv
// Directed testbench for pipe_if_stage; a small IMEM model returns an
// address-derived instruction so ID contents can be predicted per address.
module tb_pipe_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  pc_select;
    logic [31:0] branch_target, jump_target, jr_target, epc;
    logic        stall_req;
    logic [1:0]  stall_len;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] if_id_pc, if_id_npc, if_id_instr;
    logic        if_id_valid, stalled;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'h2400_0000 | {8'h00, a[23:0]};
    endfunction

    assign imem_rdata = instr_of(imem_addr);

    pipe_if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .pc_select     (pc_select),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .jr_target     (jr_target),
        .epc           (epc),
        .stall_req     (stall_req),
        .stall_len     (stall_len),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_id_pc      (if_id_pc),
        .if_id_npc     (if_id_npc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .stalled       (stalled)
    );

    // Advance one clock; inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; pc_select = 3'b000; stall_req = 1'b0; stall_len = 2'd1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; pc_select = 3'b000; stall_req = 1'b0; stall_len = 2'd1;
        branch_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0; epc = 32'h0;
        tick();
        tick();
        checks++; if (imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL reset_pc: got %h want %h", imem_addr, 32'h0040_0000); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
        checks++; if ({if_id_pc, if_id_npc, if_id_instr} !== 96'h0) begin errors++; $display("FAIL reset_ifid: got %h %h %h want zeros", if_id_pc, if_id_npc, if_id_instr); end
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL reset_stalled_lo: got %b want 0", stalled); end
        stall_req = 1'b1;
        #1;
        checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL reset_stalled_hi: got %b want 1", stalled); end
        stall_req = 1'b0;
        tick();
        checks++; if (imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL reset_hold_pc: got %h want %h", imem_addr, 32'h0040_0000); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        for (int k = 0; k < 4; k++) begin
            exp_pc = 32'h0040_0000 + 32'(4 * k);
            checks++; if (imem_addr !== exp_pc) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", k, imem_addr, exp_pc); end
            checks++; if (if_id_valid !== (k > 0)) begin errors++; $display("FAIL seq_valid%0d: got %b want %b", k, if_id_valid, k > 0); end
            if (k > 0) begin
                checks++;
                if (if_id_pc !== exp_pc - 32'd4 || if_id_npc !== exp_pc || if_id_instr !== instr_of(exp_pc - 32'd4)) begin
                    errors++;
                    $display("FAIL seq_ifid%0d: got %h %h %h want %h %h %h", k, if_id_pc, if_id_npc, if_id_instr,
                             exp_pc - 32'd4, exp_pc, instr_of(exp_pc - 32'd4));
                end
            end
            tick();
        end
    endtask

    task automatic test_branch();
        reset_dut();
        tick();
        tick();
        checks++; if (if_id_pc !== 32'h0040_0004 || imem_addr !== 32'h0040_0008) begin errors++; $display("FAIL br_setup: got id %h pc %h want 00400004 00400008", if_id_pc, imem_addr); end
        pc_select = 3'b001; branch_target = 32'h0040_0100;
        tick();
        pc_select = 3'b000;
        checks++; if (imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL br_target: got %h want %h", imem_addr, 32'h0040_0100); end
`ifdef IF_DELAY_SLOT_EN
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0040_0008 || if_id_instr !== instr_of(32'h0040_0008)) begin errors++; $display("FAIL br_slot: got %b %h %h want 1 00400008 %h", if_id_valid, if_id_pc, if_id_instr, instr_of(32'h0040_0008)); end
`else
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc !== 32'h0) begin errors++; $display("FAIL br_squash: got %b %h %h want 0 0 0", if_id_valid, if_id_pc, if_id_instr); end
`endif
        tick();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0040_0100 || if_id_instr !== instr_of(32'h0040_0100)) begin errors++; $display("FAIL br_after: got %b %h %h want 1 00400100 %h", if_id_valid, if_id_pc, if_id_instr, instr_of(32'h0040_0100)); end
        checks++; if (imem_addr !== 32'h0040_0104) begin errors++; $display("FAIL br_next: got %h want %h", imem_addr, 32'h0040_0104); end
    endtask

    task automatic test_stall();
        logic [3:0] exp_st;
        reset_dut();
        for (int k = 0; k < 4; k++) tick();
        checks++; if (imem_addr !== 32'h0040_0010 || if_id_pc !== 32'h0040_000C) begin errors++; $display("FAIL st_setup: got %h %h want 00400010 0040000c", imem_addr, if_id_pc); end
        stall_req = 1'b1; stall_len = 2'd3; pc_select = 3'b010; jump_target = 32'h0000_1000;
        exp_st = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (stalled !== exp_st[k]) begin errors++; $display("FAIL st_stalled%0d: got %b want %b", k, stalled, exp_st[k]); end
            checks++; if (imem_addr !== 32'h0040_0010) begin errors++; $display("FAIL st_pc%0d: got %h want %h", k, imem_addr, 32'h0040_0010); end
            checks++; if (if_id_pc !== 32'h0040_000C || if_id_valid !== 1'b1 || if_id_instr !== instr_of(32'h0040_000C)) begin errors++; $display("FAIL st_ifid%0d: got %h %b %h want 0040000c 1", k, if_id_pc, if_id_valid, if_id_instr); end
            if (k == 2) pc_select = 3'b000;
            tick();
            stall_req = 1'b0;
            if (k == 0) pc_select = 3'b010;
        end
        checks++; if (imem_addr !== 32'h0040_0014 || if_id_pc !== 32'h0040_0010) begin errors++; $display("FAIL st_resume: got %h %h want 00400014 00400010", imem_addr, if_id_pc); end
    endtask

    task automatic test_stall_redirect();
        reset_dut();
        stall_req = 1'b1; stall_len = 2'd1; pc_select = 3'b011; jr_target = 32'h0040_0203;
        #1;
        checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL jr_stalled: got %b want 1", stalled); end
        tick();
        stall_req = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h0040_0000 || stalled !== 1'b0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL jr_hold: got %h %b %b want 00400000 0 0", imem_addr, stalled, if_id_valid); end
        tick();
        pc_select = 3'b000;
        checks++; if (imem_addr !== 32'h0040_0200) begin errors++; $display("FAIL jr_target: got %h want %h", imem_addr, 32'h0040_0200); end
`ifdef IF_DELAY_SLOT_EN
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0040_0000) begin errors++; $display("FAIL jr_slot: got %b %h want 1 00400000", if_id_valid, if_id_pc); end
`else
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin errors++; $display("FAIL jr_squash: got %b %h want 0 0", if_id_valid, if_id_instr); end
`endif
    endtask

    task automatic test_exc_eret();
        reset_dut();
        pc_select = 3'b101;
        tick();
        checks++; if (imem_addr !== 32'h0000_0004) begin errors++; $display("FAIL exc_vec: got %h want %h", imem_addr, 32'h0000_0004); end
        pc_select = 3'b000;
        tick();
        checks++; if (imem_addr !== 32'h0000_0008 || if_id_pc !== 32'h0000_0004 || if_id_valid !== 1'b1) begin errors++; $display("FAIL exc_handler: got %h %h %b want 00000008 00000004 1", imem_addr, if_id_pc, if_id_valid); end
        pc_select = 3'b100; epc = 32'h0040_0030;
        tick();
        checks++; if (imem_addr !== 32'h0040_0030) begin errors++; $display("FAIL eret_epc: got %h want %h", imem_addr, 32'h0040_0030); end
        pc_select = 3'b110;
        tick();
        checks++; if (imem_addr !== 32'h0040_0034 || if_id_valid !== 1'b1 || if_id_pc !== 32'h0040_0030) begin errors++; $display("FAIL sel110_seq: got %h %b %h want 00400034 1 00400030", imem_addr, if_id_valid, if_id_pc); end
        pc_select = 3'b010; jump_target = 32'hFFFF_FFFF;
        tick();
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL jmp_align: got %h want %h", imem_addr, 32'hFFFF_FFFC); end
        pc_select = 3'b000;
        tick();
        checks++; if (imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL pc_wrap: got %h want %h", imem_addr, 32'h0000_0000); end
        tick();
        checks++; if (if_id_pc !== 32'h0000_0000 || if_id_npc !== 32'h0000_0004 || if_id_valid !== 1'b1) begin errors++; $display("FAIL wrap_ifid: got %h %h %b want 0 4 1", if_id_pc, if_id_npc, if_id_valid); end
    endtask

    task automatic test_rst_mid_stall();
        reset_dut();
        tick();
        tick();
        stall_req = 1'b1; stall_len = 2'd3;
        tick();
        stall_req = 1'b0;
        checks++; if (stalled !== 1'b1 || imem_addr !== 32'h0040_0008) begin errors++; $display("FAIL rs_install: got %b %h want 1 00400008", stalled, imem_addr); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (imem_addr !== 32'h0040_0000 || if_id_valid !== 1'b0 || stalled !== 1'b0) begin errors++; $display("FAIL rs_reset: got %h %b %b want 00400000 0 0", imem_addr, if_id_valid, stalled); end
        tick();
        checks++; if (imem_addr !== 32'h0040_0004 || if_id_valid !== 1'b1) begin errors++; $display("FAIL rs_run: got %h %b want 00400004 1", imem_addr, if_id_valid); end
    endtask

    initial begin
        rst = 1'b1; pc_select = 3'b000; stall_req = 1'b0; stall_len = 2'd1;
        branch_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0; epc = 32'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_stall_redirect();
        test_exc_eret();
        test_rst_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish before 100000");
        $fatal(1);
    end

endmodule
